sequence_10010_generator: RTL

SEQUENCE_10010_GENERATOR -- requirements
Module: sequence_10010_generator

---
 rtl/seq_gen_pkg.sv | 23 ++
 rtl/seq_pattern_shifter.sv | 45 ++++
 rtl/sequence_10010_generator.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern burst generator.
//   state_e      : FSM state encoding (IDLE / SEND / DONE)
//   DEF_*        : default pattern, pattern length and overlap border
//   CNT_W        : width of the burst pattern count
//   idx_width()  : bit-index register width for a given pattern length
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_PAT_LEN = 5;
  localparam logic [4:0]  DEF_PATTERN = 5'b10010;
  localparam int unsigned DEF_BORDER  = 2;
  localparam int unsigned CNT_W       = 8;

  function automatic int unsigned idx_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/seq_pattern_shifter.sv
// Loadable bit-index pattern shifter.
//   clk, reset_n : clock, asynchronous active-low reset
//   load_i       : point the index at the pattern MSB
//   adv_i        : step toward the LSB; from the LSB, jump to wrap_idx_i
//   en_i         : gate for dout_o (dout_o is 0 when low)
//   wrap_idx_i   : index reloaded after the LSB has been sent
//   dout_o       : currently selected pattern bit, gated by en_i
//   at_lsb_o     : index currently points at the LSB
module seq_pattern_shifter
  import seq_gen_pkg::*;
#(
  parameter int unsigned            PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]     PATTERN = DEF_PATTERN,
  localparam int unsigned           IDX_W   = idx_width(PAT_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] wrap_idx_i,
  output logic             dout_o,
  output logic             at_lsb_o
);

  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = IDX_W'(PAT_LEN - 1);
    end else if (adv_i) begin
      idx_d = at_lsb_o ? wrap_idx_i : idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) idx_q <= '0;
    else          idx_q <= idx_d;
  end

  assign at_lsb_o = (idx_q == '0);
  assign dout_o   = en_i & PATTERN[idx_q];

endmodule

// File: rtl/sequence_10010_generator.sv
// Serial pattern burst generator.
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : burst request (ignored unless idle)
//   count        : number of patterns in the burst, sampled with start
//   overlap      : 1 = overlapped patterns sharing BORDER bits, 0 = back-to-back
//   dout         : serial data, MSB first, 0 whenever valid is low
//   valid        : dout carries a burst bit
//   busy         : burst in progress
//   done         : one-cycle pulse after each accepted burst
// All outputs decode registered state only.
module sequence_10010_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int unsigned        BORDER  = DEF_BORDER
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             overlap,
  output logic             dout,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = idx_width(PAT_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovl_q, ovl_d;
  logic             load, adv, at_lsb;
  logic [IDX_W-1:0] wrap_idx;

  // Overlapped patterns after the first resume below the shared border bits.
  assign wrap_idx = ovl_q ? IDX_W'(PAT_LEN - BORDER - 1) : IDX_W'(PAT_LEN - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovl_d   = ovl_q;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = SEND;
            cnt_d   = count;
            ovl_d   = overlap;
            load    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEND: begin
        adv = 1'b1;
        // cnt_q holds patterns remaining including the current one, so it
        // never reaches zero while sending.
        if (at_lsb) begin
          if (cnt_q == CNT_W'(1)) state_d = DONE;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovl_q   <= ovl_d;
    end
  end

  assign valid = (state_q == SEND);
  assign busy  = (state_q == SEND);
  assign done  = (state_q == DONE);

  seq_pattern_shifter #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_shifter (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (load),
    .adv_i      (adv),
    .en_i       (valid),
    .wrap_idx_i (wrap_idx),
    .dout_o     (dout),
    .at_lsb_o   (at_lsb)
  );

endmodule
